// File: rtl/dot11_tx_sched_if.sv
// rtl/dot11_tx_sched_if.sv - request stream and PHY-core signals of the dot11_tx scheduler
interface dot11_tx_sched_if;
    logic        req_valid;
    logic        req_ready;
    logic [11:0] req_base;
    logic [6:0]  req_scram;
    logic        core_arest;
    logic        core_start;
    logic        core_done;
    logic [6:0]  core_init_data_scram;
    logic [11:0] core_bram_addr;
    logic [11:0] mem_addr;

    modport master (
        output req_valid, req_base, req_scram, core_done, core_bram_addr,
        input  req_ready, core_arest, core_start, core_init_data_scram, mem_addr
    );

    modport slave (
        input  req_valid, req_base, req_scram, core_done, core_bram_addr,
        output req_ready, core_arest, core_start, core_init_data_scram, mem_addr
    );
endinterface

// File: rtl/dot11_tx_sched.sv
// rtl/dot11_tx_sched.sv - frame sequencer for the dot11_tx PHY core with request FIFO and watchdog
module dot11_tx_sched #(
    parameter int DEPTH          = 4,
    parameter int RST_CYCLES     = 4,
    parameter int START_CYCLES   = 5,
    parameter int GAP_CYCLES     = 32,
    parameter int TIMEOUT_CYCLES = 1048575,
    parameter int TO_W           = 20
) (
    input  logic                   clk,
    input  logic                   phy_tx_arest,
    dot11_tx_sched_if.slave        bus,
    output logic                   busy,
    output logic                   done_pulse,
    output logic                   abort_pulse,
    output logic [15:0]            tx_cnt,
    output logic                   timeout_err,
    input  logic                   err_clr
);
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PH_W = 16;

    typedef enum logic [2:0] {S_IDLE, S_RST, S_START, S_WAIT, S_GAP} state_t;

    state_t          state;
    logic [11:0]     base_mem  [DEPTH];
    logic [6:0]      scram_mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     fifo_cnt;
    logic            push;
    logic            pop;
    logic [PH_W-1:0] ph_cnt;
    logic [TO_W-1:0] wd_cnt;
    logic [11:0]     cur_base;
    logic [6:0]      cur_scram;
    logic            arest_q;
    logic            start_q;

    assign bus.req_ready            = (fifo_cnt < (AW+1)'(DEPTH));
    assign push                     = bus.req_valid && bus.req_ready;
    assign pop                      = (state == S_IDLE) && (fifo_cnt != '0);
    assign bus.core_arest           = arest_q;
    assign bus.core_start           = start_q;
    assign bus.core_init_data_scram = cur_scram;
    // Combinational offset keeps the core's one-cycle BRAM read latency intact.
    assign bus.mem_addr             = cur_base + bus.core_bram_addr;
    assign busy                     = (state != S_IDLE) || (fifo_cnt != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            base_mem[wr_ptr]  <= bus.req_base;
            scram_mem[wr_ptr] <= bus.req_scram;
        end
    end

    always_ff @(posedge clk or posedge phy_tx_arest) begin
        if (phy_tx_arest) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge phy_tx_arest) begin
        if (phy_tx_arest) begin
            state       <= S_IDLE;
            ph_cnt      <= '0;
            wd_cnt      <= '0;
            cur_base    <= '0;
            cur_scram   <= 7'h7F;
            arest_q     <= 1'b1;
            start_q     <= 1'b0;
            done_pulse  <= 1'b0;
            abort_pulse <= 1'b0;
            tx_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            done_pulse  <= 1'b0;
            abort_pulse <= 1'b0;
            if (err_clr) timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        cur_base  <= base_mem[rd_ptr];
                        cur_scram <= scram_mem[rd_ptr];
                        ph_cnt    <= '0;
                        state     <= S_RST;
                    end
                end
                S_RST: begin
                    if (ph_cnt == PH_W'(RST_CYCLES - 1)) begin
                        ph_cnt  <= '0;
                        wd_cnt  <= '0;
                        arest_q <= 1'b0;
                        start_q <= 1'b1;
                        state   <= S_START;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                S_START, S_WAIT: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    // done is checked first so it wins over a coincident watchdog expiry
                    if (bus.core_done) begin
                        done_pulse <= 1'b1;
                        tx_cnt     <= tx_cnt + 1'b1;
                        ph_cnt     <= '0;
                        arest_q    <= 1'b1;
                        start_q    <= 1'b0;
                        state      <= S_GAP;
                    end else if (wd_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        abort_pulse <= 1'b1;
                        timeout_err <= 1'b1;
                        ph_cnt      <= '0;
                        arest_q     <= 1'b1;
                        start_q     <= 1'b0;
                        state       <= S_GAP;
                    end else if (state == S_START) begin
                        if (ph_cnt == PH_W'(START_CYCLES - 1)) begin
                            start_q <= 1'b0;
                            state   <= S_WAIT;
                        end else begin
                            ph_cnt <= ph_cnt + 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (ph_cnt == PH_W'(GAP_CYCLES - 1)) begin
                        ph_cnt <= '0;
                        state  <= S_IDLE;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                default: begin
                    arest_q <= 1'b1;
                    start_q <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dot11_tx_sched.sv
// tb/tb_dot11_tx_sched.sv - randomized self-checking bench for dot11_tx_sched
module tb_dot11_tx_sched;
    localparam int DEPTH   = 4;
    localparam int RST_C   = 4;
    localparam int START_C = 5;
    localparam int GAP_C   = 32;
    localparam int TMO     = 2100;
    localparam int TO_W    = 12;

    logic        clk = 1'b0;
    logic        phy_tx_arest;
    logic        err_clr;
    logic        busy;
    logic        done_pulse;
    logic        abort_pulse;
    logic        timeout_err;
    logic [15:0] tx_cnt;

    dot11_tx_sched_if bus ();

    dot11_tx_sched #(
        .DEPTH(DEPTH), .RST_CYCLES(RST_C), .START_CYCLES(START_C),
        .GAP_CYCLES(GAP_C), .TIMEOUT_CYCLES(TMO), .TO_W(TO_W)
    ) dut (
        .clk(clk), .phy_tx_arest(phy_tx_arest), .bus(bus), .busy(busy),
        .done_pulse(done_pulse), .abort_pulse(abort_pulse), .tx_cnt(tx_cnt),
        .timeout_err(timeout_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [18:0] exp_q[$];
    int          tx_model   = 0;
    bit          terr_model = 1'b0;
    int          last_start = 0;
    int          last_len   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [11:0] b, input logic [6:0] s);
        int n;
        n = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_base  = b;
        bus.req_scram = s;
        while (!bus.req_ready && n < 10000) begin
            @(negedge clk);
            n++;
        end
        check_eq("push_accepted", bus.req_ready, 1);
        @(posedge clk);
        exp_q.push_back({b, s});
        #1 bus.req_valid = 1'b0;
    endtask

    // lat < 0 means the core never reports done.
    task automatic run_frame(input int lat, input bit chk_idle, input bit b2b, input bit clr_at_expiry);
        int n, endk, n_low, n_start, n_done, n_abort, done_k, abort_k;
        bit normal;
        logic [18:0] e;
        logic [11:0] a;
        n = 0; n_low = 0; n_start = 0; n_done = 0; n_abort = 0; done_k = -1; abort_k = -1;
        @(negedge clk);
        while (bus.core_arest && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check_eq("frame_started", bus.core_arest, 0);
        check_eq("frame_expected", exp_q.size() > 0, 1);
        if (bus.core_arest || exp_q.size() == 0) return;
        e = exp_q.pop_front();
        check_eq("scram_seed", bus.core_init_data_scram, e[6:0]);
        if (b2b) check_eq("start_spacing", cyc - last_start, 1 + RST_C + last_len + GAP_C);
        last_start = cyc;
        normal = (lat >= 0) && (lat <= TMO - 1);
        endk   = normal ? lat + 1 : TMO;
        for (int k = 0; k <= endk + GAP_C; k++) begin
            if (k > 0) @(negedge clk);
            a = (e[18:7] == 12'hFF0 && k == 0) ? 12'h020 : 12'($urandom);
            bus.core_bram_addr = a;
            #1;
            check_eq("mem_addr", bus.mem_addr, (int'(e[18:7]) + int'(a)) % 4096);
            if (!bus.core_arest) n_low++;
            if (bus.core_start)  n_start++;
            if (done_pulse)  begin n_done++;  done_k  = k; end
            if (abort_pulse) begin n_abort++; abort_k = k; end
            if (chk_idle && k == endk + GAP_C - 1) check_eq("busy_in_gap", busy, 1);
            if (chk_idle && k == endk + GAP_C)     check_eq("busy_after_gap", busy, 0);
            bus.core_done = (k == lat);
            err_clr       = clr_at_expiry && (k == TMO - 1);
        end
        bus.core_done = 1'b0;
        err_clr       = 1'b0;
        if (normal) tx_model++;
        else        terr_model = 1'b1;
        check_eq("arest_low_cycles", n_low, endk);
        check_eq("start_high_cycles", n_start, (endk < START_C) ? endk : START_C);
        check_eq("done_pulses", n_done, normal ? 1 : 0);
        check_eq("abort_pulses", n_abort, normal ? 0 : 1);
        if (normal) check_eq("done_cycle", done_k, endk);
        else        check_eq("abort_cycle", abort_k, endk);
        check_eq("tx_cnt", tx_cnt, tx_model % 65536);
        check_eq("timeout_err", timeout_err, terr_model);
        last_len = endk;
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation time %0t exceeded bound", $time);
        $fatal(1);
    end

    initial begin
        int n, q_pulse, q_low, q_busy;
        phy_tx_arest       = 1'b1;
        err_clr            = 1'b0;
        bus.req_valid      = 1'b0;
        bus.req_base       = '0;
        bus.req_scram      = '0;
        bus.core_done      = 1'b0;
        bus.core_bram_addr = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_core_arest", bus.core_arest, 1);
        check_eq("rst_core_start", bus.core_start, 0);
        check_eq("rst_scram", bus.core_init_data_scram, 7'h7F);
        check_eq("rst_tx_cnt", tx_cnt, 0);
        check_eq("rst_timeout_err", timeout_err, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ready", bus.req_ready, 1);
        check_eq("rst_pulses", {done_pulse, abort_pulse}, 0);
        phy_tx_arest = 1'b0;

        // single long frame, done 2000 cycles after start falls
        push(12'h000, 7'h7F);
        run_frame(START_C + 2000, 1, 0, 0);

        // fill the FIFO while a frame is in WAIT, then run six frames back to back
        push(12'($urandom), 7'($urandom));
        fork
            begin
                run_frame(300, 0, 0, 0);
                for (int i = 0; i < 6; i++)
                    run_frame($urandom_range(0, 60), i == 5, 1, 0);
            end
            begin
                int m;
                m = 0;
                @(negedge clk);
                while (!bus.core_start && m < 2000) begin
                    @(negedge clk);
                    m++;
                end
                for (int i = 0; i < 6; i++) begin
                    if (i < 4) begin
                        @(negedge clk);
                        check_eq("ready_not_full", bus.req_ready, 1);
                    end
                    push((i == 2) ? 12'hFF0 : 12'($urandom), 7'($urandom));
                    if (i == 3) begin
                        @(negedge clk);
                        check_eq("ready_full", bus.req_ready, 0);
                    end
                end
            end
        join

        // watchdog abort followed by a queued frame, then clear the sticky flag
        push(12'($urandom), 7'($urandom));
        push(12'($urandom), 7'($urandom));
        run_frame(-1, 0, 0, 0);
        run_frame($urandom_range(0, 60), 1, 1, 0);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        terr_model = 1'b0;
        check_eq("err_clr", timeout_err, 0);

        // done coincident with watchdog expiry
        push(12'($urandom), 7'($urandom));
        run_frame(TMO - 1, 1, 0, 0);

        // abort coincident with err_clr: set wins
        push(12'($urandom), 7'($urandom));
        run_frame(-1, 1, 0, 1);

        // reset mid-WAIT with two requests queued
        push(12'($urandom), 7'($urandom));
        push(12'($urandom), 7'($urandom));
        push(12'($urandom), 7'($urandom));
        n = 0;
        @(negedge clk);
        while (bus.core_arest && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_eq("rst_test_started", bus.core_arest, 0);
        repeat (10) @(negedge clk);
        phy_tx_arest = 1'b1;
        #1;
        check_eq("mid_rst_core_arest", bus.core_arest, 1);
        check_eq("mid_rst_core_start", bus.core_start, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_ready", bus.req_ready, 1);
        check_eq("mid_rst_tx_cnt", tx_cnt, 0);
        check_eq("mid_rst_timeout_err", timeout_err, 0);
        check_eq("mid_rst_pulses", {done_pulse, abort_pulse}, 0);
        exp_q.delete();
        tx_model   = 0;
        terr_model = 1'b0;
        @(negedge clk);
        phy_tx_arest = 1'b0;
        q_pulse = 0; q_low = 0; q_busy = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (done_pulse || abort_pulse) q_pulse++;
            if (!bus.core_arest) q_low++;
            if (busy) q_busy++;
        end
        check_eq("post_rst_pulses", q_pulse, 0);
        check_eq("post_rst_arest_low", q_low, 0);
        check_eq("post_rst_busy", q_busy, 0);

        push(12'($urandom), 7'($urandom));
        run_frame($urandom_range(0, 60), 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
